// File: rtl/ecc_codec_pipe.sv
// Two-stage pipelined SEC-DED Hamming codec with valid/ready flow control.
// Provides encode and decode/correct modes, and saturating SEC/DED event counters.
module ecc_codec_pipe #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16,
    localparam int R = (DATA_WIDTH <= 11)  ? 4 :
                       (DATA_WIDTH <= 26)  ? 5 :
                       (DATA_WIDTH <= 57)  ? 6 :
                       (DATA_WIDTH <= 120) ? 7 : 8,
    localparam int CODE_WIDTH = R + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CODE_WIDTH-1:0] in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CODE_WIDTH-1:0] out_code,
    output logic                  out_sec,
    output logic                  out_ded,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  cnt_sec,
    output logic [CNT_WIDTH-1:0]  cnt_ded
);

    localparam int N  = DATA_WIDTH + R;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Check bits c[R-1:0]; power-of-two positions hold check bits, the rest carry data.
    function automatic logic [R-1:0] calc_check(input logic [DATA_WIDTH-1:0] d);
        logic [R-1:0] c;
        int di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[di[IW-1:0]]) begin
                    c = c ^ pos[R-1:0];
                end
                di = di + 1;
            end
        end
        return c;
    endfunction

    // One-hot data mask for the data bit living at codeword position s.
    function automatic logic [DATA_WIDTH-1:0] flip_mask(input logic [R-1:0] s);
        logic [DATA_WIDTH-1:0] m;
        int di;
        m  = '0;
        di = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (pos == int'(s)) begin
                    m[di[IW-1:0]] = 1'b1;
                end
                di = di + 1;
            end
        end
        return m;
    endfunction

    function automatic logic is_pow2(input logic [R-1:0] v);
        return ((v & (v - R'(1))) == '0);
    endfunction

    logic                  en_s;
    logic [R-1:0]          chk_s;
    logic [R-1:0]          s_d;
    logic                  p_d;

    logic                  v1_q;
    logic                  mode1_q;
    logic [DATA_WIDTH-1:0] data1_q;
    logic [CODE_WIDTH-1:0] code1_q;
    logic [R-1:0]          s1_q;
    logic                  p1_q;

    logic [DATA_WIDTH-1:0] data_d;
    logic [CODE_WIDTH-1:0] code_d;
    logic                  sec_d;
    logic                  ded_d;

    logic                  out_valid_q;
    logic                  out_mode_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CODE_WIDTH-1:0] out_code_q;
    logic                  out_sec_q;
    logic                  out_ded_q;

    logic [CNT_WIDTH-1:0]  cnt_sec_q;
    logic [CNT_WIDTH-1:0]  cnt_ded_q;
    logic [CNT_WIDTH-1:0]  cnt_sec_d;
    logic [CNT_WIDTH-1:0]  cnt_ded_d;

    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    // Stage-1 syndrome/parity; in encode mode s carries the fresh check bits and p the overall parity.
    always_comb begin
        chk_s = calc_check(in_data);
        if (in_mode) begin
            s_d = chk_s ^ in_code[R-1:0];
            p_d = (^in_data) ^ (^in_code);
        end else begin
            s_d = chk_s;
            p_d = (^in_data) ^ (^chk_s);
        end
    end

    // Stage-1 register; payload only loads on a real transaction so idle inputs leave no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            mode1_q <= 1'b0;
            data1_q <= '0;
            code1_q <= '0;
            s1_q    <= '0;
            p1_q    <= 1'b0;
        end else if (en_s) begin
            v1_q <= in_valid;
            if (in_valid) begin
                mode1_q <= in_mode;
                data1_q <= in_data;
                code1_q <= in_mode ? in_code : '0;
                s1_q    <= s_d;
                p1_q    <= p_d;
            end
        end
    end

    // Stage-2 classification and correction.
    always_comb begin
        data_d = data1_q;
        code_d = code1_q;
        sec_d  = 1'b0;
        ded_d  = 1'b0;
        if (!mode1_q) begin
            code_d = {p1_q, s1_q};
        end else if (p1_q) begin
            if (s1_q == '0) begin
                code_d[R] = ~code1_q[R];
                sec_d     = 1'b1;
            end else if (int'(s1_q) > N) begin
                ded_d = 1'b1;
            end else if (is_pow2(s1_q)) begin
                code_d[R-1:0] = code1_q[R-1:0] ^ s1_q;
                sec_d         = 1'b1;
            end else begin
                data_d = data1_q ^ flip_mask(s1_q);
                sec_d  = 1'b1;
            end
        end else if (s1_q != '0) begin
            ded_d = 1'b1;
        end else begin
            data_d = data1_q;
        end
    end

    // Stage-2 output register; holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_data_q  <= '0;
            out_code_q  <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
        end else if (en_s) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_mode_q <= mode1_q;
                out_data_q <= data_d;
                out_code_q <= code_d;
                out_sec_q  <= sec_d;
                out_ded_q  <= ded_d;
            end
        end
    end

    // Counter next-state: clear wins over a same-cycle delivered event; saturate at all ones.
    always_comb begin
        cnt_sec_d = cnt_sec_q;
        cnt_ded_d = cnt_ded_q;
        if (cnt_clr) begin
            cnt_sec_d = '0;
            cnt_ded_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_sec_q && (cnt_sec_q != '1)) begin
                cnt_sec_d = cnt_sec_q + CNT_WIDTH'(1);
            end else begin
                cnt_sec_d = cnt_sec_q;
            end
            if (out_ded_q && (cnt_ded_q != '1)) begin
                cnt_ded_d = cnt_ded_q + CNT_WIDTH'(1);
            end else begin
                cnt_ded_d = cnt_ded_q;
            end
        end else begin
            cnt_sec_d = cnt_sec_q;
            cnt_ded_d = cnt_ded_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_sec_q <= '0;
            cnt_ded_q <= '0;
        end else begin
            cnt_sec_q <= cnt_sec_d;
            cnt_ded_q <= cnt_ded_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_data  = out_data_q;
    assign out_code  = out_code_q;
    assign out_sec   = out_sec_q;
    assign out_ded   = out_ded_q;
    assign cnt_sec   = cnt_sec_q;
    assign cnt_ded   = cnt_ded_q;

endmodule

// File: tb/tb_ecc_codec_pipe.sv
// Scoreboard bench for ecc_codec_pipe: directed vectors with hand-computed codes,
// a negedge monitor popping expectations, stall/hold, counter and reset scenarios.
module tb_ecc_codec_pipe;

    localparam int DW = 128;
    localparam int CW = 9;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_code;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_code;
    logic          out_sec;
    logic          out_ded;
    logic          cnt_clr;
    logic [NW-1:0] cnt_sec;
    logic [NW-1:0] cnt_ded;

    typedef struct packed {
        logic          mode;
        logic [DW-1:0] data;
        logic [CW-1:0] code;
        logic          sec;
        logic          ded;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ecc_codec_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .in_code  (in_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_data (out_data),
        .out_code (out_code),
        .out_sec  (out_sec),
        .out_ded  (out_ded),
        .cnt_clr  (cnt_clr),
        .cnt_sec  (cnt_sec),
        .cnt_ded  (cnt_ded)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Drive one transaction (called at posedge+1), wait for acceptance, queue expectation.
    task automatic send(input logic m, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                        input logic es, input logic edd);
        exp_t e;
        bit   acc;
        int   guard;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_code  = c;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 50) begin
            #2;
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (acc) begin
            e.mode = m;
            e.data = ed;
            e.code = ec;
            e.sec  = es;
            e.ded  = edd;
            sb.push_back(e);
        end else begin
            check("send_timeout", DW'(1'b0), DW'(1'b1));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each delivered output, checks hold during stalls and the ready rule.
    initial begin
        exp_t e;
        exp_t hold_e;
        bit   held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready_rule", DW'(in_ready), DW'(!out_valid || out_ready));
                if (held && out_valid) begin
                    check("hold_data", out_data, hold_e.data);
                    check("hold_code", DW'(out_code), DW'(hold_e.code));
                    check("hold_flags", DW'({out_mode, out_sec, out_ded}),
                          DW'({hold_e.mode, hold_e.sec, hold_e.ded}));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", DW'(1'b1), DW'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        check("out_mode", DW'(out_mode), DW'(e.mode));
                        check("out_data", out_data, e.data);
                        check("out_code", DW'(out_code), DW'(e.code));
                        check("out_sec", DW'(out_sec), DW'(e.sec));
                        check("out_ded", DW'(out_ded), DW'(e.ded));
                    end
                end
                held            = out_valid && !out_ready;
                hold_e.mode     = out_mode;
                hold_e.data     = out_data;
                hold_e.code     = out_code;
                hold_e.sec      = out_sec;
                hold_e.ded      = out_ded;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d127;
        logic [DW-1:0] d127_1;
        d0        = '0;
        d1        = '0;
        d1[0]     = 1'b1;
        d2        = '0;
        d2[1]     = 1'b1;
        d127      = '0;
        d127[127] = 1'b1;
        d127_1    = d127 | d1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(1'b0));
        check("rst_out_data", out_data, d0);
        check("rst_out_code", DW'(out_code), DW'(9'h000));
        check("rst_flags", DW'({out_mode, out_sec, out_ded}), DW'(3'b000));
        check("rst_cnts", DW'({cnt_sec, cnt_ded}), DW'(4'h0));
        rst_n = 1'b1;
        check("rdy_after_rst", DW'(in_ready), DW'(1'b1));

        // Encode zero, with a two-cycle latency probe.
        send(1'b0, d0, 9'h1AA, d0, 9'h000, 1'b0, 1'b0);
        check("lat_cycle1", DW'(out_valid), DW'(1'b0));
        @(posedge clk);
        #1;
        check("lat_cycle2", DW'(out_valid), DW'(1'b1));
        drain();

        send(1'b0, d1, 9'h000, d1, 9'h103, 1'b0, 1'b0);
        send(1'b1, d1, 9'h103, d1, 9'h103, 1'b0, 1'b0);
        drain();
        check("cnt_clean", DW'({cnt_sec, cnt_ded}), DW'(4'h0));

        send(1'b1, d0, 9'h103, d1, 9'h103, 1'b1, 1'b0);
        drain();
        check("cnt_sec_1", DW'(cnt_sec), DW'(2'd1));
        send(1'b1, d1, 9'h102, d1, 9'h103, 1'b1, 1'b0);
        drain();
        check("cnt_sec_2", DW'(cnt_sec), DW'(2'd2));
        send(1'b1, d2, 9'h103, d2, 9'h103, 1'b0, 1'b1);
        drain();
        check("cnt_ded_1", DW'(cnt_ded), DW'(2'd1));

        // Overall-parity bit, top data bit, out-of-range syndrome, check-bit 0; saturation.
        send(1'b1, d0, 9'h100, d0, 9'h000, 1'b1, 1'b0);
        send(1'b1, d0, 9'h188, d127, 9'h188, 1'b1, 1'b0);
        send(1'b1, d0, 9'h1FF, d0, 9'h1FF, 1'b0, 1'b1);
        send(1'b0, d127, 9'h000, d127, 9'h188, 1'b0, 1'b0);
        send(1'b0, d127_1, 9'h000, d127_1, 9'h08B, 1'b0, 1'b0);
        send(1'b1, d0, 9'h001, d0, 9'h000, 1'b1, 1'b0);
        drain();
        check("cnt_sec_sat", DW'(cnt_sec), DW'(2'd3));
        check("cnt_ded_2", DW'(cnt_ded), DW'(2'd2));

        // Idle inputs with garbage payload must change nothing.
        in_mode = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_code = 9'h0AB;
        repeat (5) @(posedge clk);
        #1;
        check("idle_valid", DW'(out_valid), DW'(1'b0));
        check("idle_cnts", DW'({cnt_sec, cnt_ded}), DW'({2'd3, 2'd2}));

        // Back-to-back stream with a three-cycle downstream stall.
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(1'b0, d0, 9'h000, d0, 9'h000, 1'b0, 1'b0);
        send(1'b0, d1, 9'h000, d1, 9'h103, 1'b0, 1'b0);
        send(1'b1, d1, 9'h103, d1, 9'h103, 1'b0, 1'b0);
        send(1'b1, d0, 9'h103, d1, 9'h103, 1'b1, 1'b0);
        send(1'b1, d2, 9'h103, d2, 9'h103, 1'b0, 1'b1);
        send(1'b0, d127, 9'h000, d127, 9'h188, 1'b0, 1'b0);
        send(1'b1, d0, 9'h188, d127, 9'h188, 1'b1, 1'b0);
        send(1'b0, d127_1, 9'h000, d127_1, 9'h08B, 1'b0, 1'b0);
        drain();
        drain();
        check("stream_drained", DW'(sb.size()), DW'(0));

        // Clear alone, then clear colliding with a delivered SEC.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_alone", DW'({cnt_sec, cnt_ded}), DW'(4'h0));
        send(1'b1, d0, 9'h103, d1, 9'h103, 1'b1, 1'b0);
        drain();
        check("cnt_after_clr", DW'(cnt_sec), DW'(2'd1));
        send(1'b1, d0, 9'h103, d1, 9'h103, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_priority", DW'(cnt_sec), DW'(2'd0));
        drain();
        send(1'b1, d1, 9'h102, d1, 9'h103, 1'b1, 1'b0);
        drain();
        check("cnt_pre_rst", DW'(cnt_sec), DW'(2'd1));

        // Reset with two transactions in flight.
        send(1'b1, d0, 9'h103, d1, 9'h103, 1'b1, 1'b0);
        send(1'b0, d1, 9'h000, d1, 9'h103, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_fl_valid", DW'(out_valid), DW'(1'b0));
        check("rst_fl_cnts", DW'({cnt_sec, cnt_ded}), DW'(4'h0));
        sb.delete();
        rst_n = 1'b1;
        check("rst_fl_ready", DW'(in_ready), DW'(1'b1));
        drain();
        send(1'b0, d127, 9'h000, d127, 9'h188, 1'b0, 1'b0);
        drain();
        check("final_empty", DW'(sb.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_codec_pipe.md
ECC_CODEC_PIPE -- requirements
Module: ecc_codec_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, legal range 8..247: protected data width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: width of each error counter.
REQ-003 The block SHALL derive localparam R as the smallest integer with 2^R >= DATA_WIDTH+R+1 (R=8 at 128), and CODE_WIDTH = R+1.
REQ-004 The block SHALL have one clock and a synchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 in_valid  in  1  input transaction valid.
REQ-007 in_ready  out  1  input accepted when in_valid&&in_ready.
REQ-008 in_mode  in  1  0=encode, 1=decode/correct.
REQ-009 in_data  in  DATA_WIDTH  payload.
REQ-010 in_code  in  CODE_WIDTH  stored check bits (decode only; ignored in encode).
REQ-011 out_valid  out  1  output transaction valid.
REQ-012 out_ready  in  1  downstream accepts when out_valid&&out_ready.
REQ-013 out_mode  out  1  mode of the output transaction.
REQ-014 out_data  out  DATA_WIDTH  payload (corrected in decode).
REQ-015 out_code  out  CODE_WIDTH  generated check bits (encode) or corrected check bits (decode).
REQ-016 out_sec  out  1  single error corrected.
REQ-017 out_ded  out  1  uncorrectable error detected.
REQ-018 cnt_clr  in  1  synchronous clear of both counters.
REQ-019 cnt_sec  out  CNT_WIDTH  saturating count of delivered SEC events.
REQ-020 cnt_ded  out  CNT_WIDTH  saturating count of delivered DED events.

Function
REQ-021 Code layout SHALL be: codeword positions 1..DATA_WIDTH+R; check bit c[k] at position 2^k (k<R); data bits in ascending index at remaining positions in ascending order (data[0]=pos3, data[1]=pos5, data[2]=pos6, data[3]=pos7, data[4]=pos9).
REQ-022 c[k] (k<R) SHALL be XOR of all data bits whose position has bit k set; c[R] SHALL be XOR of all data bits and c[R-1:0] (overall parity).
REQ-023 Encode SHALL output out_data=in_data, out_code=c, out_sec=0, out_ded=0.
REQ-024 Decode SHALL compute syndrome s = recomputed c[R-1:0] XOR in_code[R-1:0] and p = XOR of all in_data and in_code bits.
REQ-025 Decode classification: s=0,p=0 -> clean, pass through; p=1,s=0 -> flip code bit R, sec=1; p=1,s=2^k -> flip code bit k, sec=1; p=1,s=data position -> flip that data bit, sec=1; p=1,s>DATA_WIDTH+R -> ded=1, no correction; s!=0,p=0 -> ded=1, no correction.
REQ-026 Stage 1 SHALL register input fields plus s and p; stage 2 SHALL apply correction and register all out_* fields; latency 2 cycles from acceptance to out_valid with no stall.
REQ-027 Pipeline enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en; both stages advance only when en=1; bubbles propagate as valid=0.
REQ-028 While out_valid=1 and out_ready=0, all out_* SHALL hold stable and no input SHALL be accepted.
REQ-029 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-030 cnt_sec/cnt_ded SHALL increment by 1 on out_valid&&out_ready with out_sec/out_ded=1 respectively, saturating at all ones.
REQ-031 cnt_clr=1 SHALL zero both counters next cycle, taking priority over a simultaneous increment.
REQ-032 in_data/in_code values with in_valid=0 SHALL have no effect on outputs or counters.

Reset
REQ-033 rst_n=0 at a clock edge SHALL clear both stage valids, out_valid, out_sec, out_ded, out_mode, out_data, out_code, cnt_sec, cnt_ded to 0; in-flight transactions SHALL be discarded.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release (out_valid=0).

Verification
REQ-035 DATA_WIDTH=128, encode data=0 -> out_code=0x000 two cycles later, sec=ded=0.
REQ-036 Encode data=0x1 -> out_code=0x103; decode data=0x1,code=0x103 -> out_data=0x1, sec=0, ded=0.
REQ-037 Decode data=0x0,code=0x103 -> out_data=0x1, out_code=0x103, sec=1, cnt_sec 0->1; decode data=0x1,code=0x102 -> out_code=0x103, sec=1.
REQ-038 Decode data=0x2,code=0x103 -> ded=1, out_data=0x2 unchanged, cnt_ded 0->1.
REQ-039 Back-to-back stream with out_ready low 3 cycles mid-stream -> in_ready low same cycles, outputs held, no loss/duplication, order preserved.
REQ-040 CNT_WIDTH=2, five SEC decodes -> cnt_sec saturates at 3; cnt_clr with simultaneous SEC -> 0; rst_n low with two in flight -> out_valid=0 next cycle, counters 0.
